// File: rtl/reset_sequencer.sv
// Staged reset release sequencer: debounced board button, software request, and power-on reset
// feed a HOLD -> STAGE1 -> STAGE2 -> RUN sequence that frees peripherals, memory, then the CPU.
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8,
    parameter int STAGE_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_n_i,
    input  logic       sw_reset_i,
    output logic       periph_reset_o,
    output logic       mem_reset_o,
    output logic       cpu_reset_o,
    output logic       cpu_resetn_o,
    output logic       boot_done_o,
    output logic [1:0] reset_cause_o
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [1:0] CAUSE_POWER_ON = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON   = 2'b01;
    localparam logic [1:0] CAUSE_SOFTWARE = 2'b10;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        STAGE1 = 2'b01,
        STAGE2 = 2'b10,
        RUN    = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_pressed;
    logic                   db_pressed;
    logic                   db_pressed_d;
    logic [DB_W-1:0]        db_cnt;
    logic                   press_event;
    logic                   button_req;
    logic                   req;

    state_t                 state_q, state_next;
    logic [CNT_W-1:0]       cnt_q, cnt_next;
    logic                   periph_next, mem_next, cpu_next, boot_next;
    logic [1:0]             cause_next;

    // Flops reset to 1 so a released button is seen while the chain fills.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_n_i};
        end
    end

    assign synced_pressed = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_pressed   <= 1'b0;
            db_pressed_d <= 1'b0;
            db_cnt       <= '0;
        end else begin
            db_pressed_d <= db_pressed;
            if (synced_pressed != db_pressed) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_pressed <= synced_pressed;
                    db_cnt     <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press_event = db_pressed & ~db_pressed_d;
    assign button_req  = press_event | db_pressed;
    assign req         = button_req | sw_reset_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= HOLD;
            cnt_q          <= '0;
            periph_reset_o <= 1'b1;
            mem_reset_o    <= 1'b1;
            cpu_reset_o    <= 1'b1;
            boot_done_o    <= 1'b0;
            reset_cause_o  <= CAUSE_POWER_ON;
        end else begin
            state_q        <= state_next;
            cnt_q          <= cnt_next;
            periph_reset_o <= periph_next;
            mem_reset_o    <= mem_next;
            cpu_reset_o    <= cpu_next;
            boot_done_o    <= boot_next;
            reset_cause_o  <= cause_next;
        end
    end

    // A request overrides every state; otherwise each stage counts out and releases one reset.
    always_comb begin
        state_next  = state_q;
        cnt_next    = cnt_q;
        periph_next = periph_reset_o;
        mem_next    = mem_reset_o;
        cpu_next    = cpu_reset_o;
        boot_next   = boot_done_o;
        cause_next  = reset_cause_o;

        if (req) begin
            state_next  = HOLD;
            cnt_next    = '0;
            periph_next = 1'b1;
            mem_next    = 1'b1;
            cpu_next    = 1'b1;
            boot_next   = 1'b0;
            cause_next  = button_req ? CAUSE_BUTTON : CAUSE_SOFTWARE;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        periph_next = 1'b0;
                        cnt_next    = '0;
                        state_next  = STAGE1;
                    end else begin
                        cnt_next = cnt_q + CNT_W'(1);
                    end
                end
                STAGE1: begin
                    if (cnt_q == CNT_W'(STAGE_CYCLES - 1)) begin
                        mem_next   = 1'b0;
                        cnt_next   = '0;
                        state_next = STAGE2;
                    end else begin
                        cnt_next = cnt_q + CNT_W'(1);
                    end
                end
                STAGE2: begin
                    if (cnt_q == CNT_W'(STAGE_CYCLES - 1)) begin
                        cpu_next   = 1'b0;
                        boot_next  = 1'b1;
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    state_next = RUN;
                end
                default: begin
                    state_next  = HOLD;
                    cnt_next    = '0;
                    periph_next = 1'b1;
                    mem_next    = 1'b1;
                    cpu_next    = 1'b1;
                    boot_next   = 1'b0;
                end
            endcase
        end
    end

    assign cpu_resetn_o = ~cpu_reset_o;

endmodule
